spi_slave_receiver: RTL and testbench

- Receive-side counterpart of the on-chip write-only SPI master (LSB-first, N_bit-bit frames, csn active-low, sclk idle high, mosi launched on sclk rising edge).
- Oversamples spi_sclk, spi_csn and spi_mosi in the clk domain and shifts in one bit per sclk falling edge while csn is low.
- On csn deassertion, validates the bit count. On a valid frame it presents the parallel word with a one-cycle strobe; on a bad frame it flags an error.
- Sits behind the FPGA/chip pins, feeding the configuration/register-load logic.

---
 rtl/spi_slave_receiver.sv | 149 ++++++++++++++
 tb/tb_spi_slave_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_receiver.sv
// rtl/spi_slave_receiver.sv - LSB-first SPI frame receiver, oversampled in the clk domain
// Accepts only N_bit-bit frames; presents the word with an rvalid pulse or flags frame_err.
module spi_slave_receiver #(
  parameter int N_bit       = 96,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             spi_sclk,
  input  logic             spi_csn,
  input  logic             spi_mosi,
  output logic [N_bit-1:0] rdata,
  output logic             rvalid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(N_bit + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_bit);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N_bit + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   csn_prev;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  logic             sclk_s;
  logic             csn_s;
  logic             mosi_s;
  logic             sclk_fall;
  logic             csn_fall;
  logic             csn_rise;
  logic             csn_fall_ok;

  logic [N_bit-1:0] shreg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_inc;
  logic [CW-1:0]    count_eff;
  logic             clr;
  logic             shift_en;

  // Reset values of sclk/csn chains are 1 so reset release never looks like an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_sync <= '1;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b1;
      csn_prev  <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      csn_prev  <= csn_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      // Only a csn high really sampled from the pin arms frame start, so csn held
      // low through reset cannot fake a falling edge once the reset values flush out.
      if (fill[SYNC_STAGES] && csn_prev && csn_sync[SYNC_STAGES-1])
        armed <= 1'b1;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign csn_s       = csn_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall   = sclk_prev & ~sclk_s;
  assign csn_fall    = csn_prev & ~csn_s;
  assign csn_rise    = ~csn_prev & csn_s;
  assign csn_fall_ok = csn_fall & armed;

  assign count_inc = (count != CNT_MAX) ? count + CW'(1) : count;
  // A final sclk fall coinciding with csn rise still counts toward the length check.
  assign count_eff = sclk_fall ? count_inc : count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall_ok) begin
          state_next = RECV;
          clr        = 1'b1;
        end
      end
      RECV: begin
        shift_en = sclk_fall;
        if (csn_rise)
          state_next = (count_eff == CNT_FULL) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (csn_fall_ok) begin
          state_next = RECV;
          clr        = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg     <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr) begin
        shreg <= '0;
        count <= '0;
      end else if (shift_en) begin
        shreg <= {mosi_s, shreg[N_bit-1:1]};
        count <= count_inc;
      end
      if (state == DONE)
        rdata <= shreg;
      rvalid    <= (state == DONE);
      frame_err <= (state == ERR);
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb/tb_spi_slave_receiver.sv - scoreboard bench for spi_slave_receiver
// Stimulus pushes expected rvalid/frame_err events; a monitor pops and compares them.
module tb_spi_slave_receiver;

  localparam int NB = 96;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          spi_sclk = 1'b1;
  logic          spi_csn = 1'b1;
  logic          spi_mosi = 1'b0;
  logic [NB-1:0] rdata;
  logic          rvalid;
  logic          frame_err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit            is_err;
    logic [NB-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] last_good = '0;

  spi_slave_receiver #(.N_bit(NB), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .spi_sclk  (spi_sclk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ok(input logic [NB-1:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
    last_good = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    exp_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [127:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[i];
      wait_clk(4);
      spi_sclk = 1'b0;
      wait_clk(4);
      spi_sclk = 1'b1;
      if (i == n / 2) begin
        @(negedge clk);
        check("busy_mid_frame", NB'(busy), NB'(1));
      end
    end
  endtask

  task automatic send_frame(input logic [127:0] d, input int n, input int gap);
    spi_csn = 1'b0;
    wait_clk(4);
    shift_bits(d, n);
    wait_clk(4);
    spi_csn = 1'b1;
    wait_clk(gap);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, NB'(busy), NB'(0));
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst && (rvalid || frame_err)) begin
        n_checks++;
        if (rvalid && frame_err) begin
          n_fail++;
          $display("FAIL pulse_both: rvalid=1 frame_err=1, expected only one");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: rvalid=%0b frame_err=%0b rdata=%0h, expected no pulse",
                   rvalid, frame_err, rdata);
        end else begin
          e = exp_q.pop_front();
          if (frame_err !== e.is_err || rdata !== e.data) begin
            n_fail++;
            $display("FAIL scoreboard: got err=%0b rdata=%0h, expected err=%0b rdata=%0h",
                     frame_err, rdata, e.is_err, e.data);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    wait_clk(3);
    check("reset_rdata", rdata, '0);
    check("reset_rvalid", NB'(rvalid), NB'(0));
    check("reset_frame_err", NB'(frame_err), NB'(0));
    check("reset_busy", NB'(busy), NB'(0));
    nrst = 1'b1;
    wait_clk(10);

    // Master-style frame
    expect_ok(96'hA5A5_0000_1234_5678_9ABC_DEF0);
    send_frame(128'hA5A5_0000_1234_5678_9ABC_DEF0, 96, 12);
    check_idle("busy_after_frame");

    // Valid, then short, then long
    expect_ok(96'h1);
    send_frame(128'h1, 96, 12);
    expect_err();
    send_frame({128{1'b1}}, 95, 12);
    check_idle("busy_after_short");
    expect_err();
    send_frame(128'h1_F0F0_1111_2222_3333_4444_5555, 97, 12);
    check_idle("busy_after_long");

    // sclk activity with csn high must be ignored
    for (int i = 0; i < 10; i++) begin
      spi_sclk = 1'b0;
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
      if (i == 5) check_idle("busy_csn_high");
    end
    wait_clk(8);
    expect_ok({NB{1'b1}});
    send_frame({128{1'b1}}, 96, 12);

    // Reset in the middle of a frame
    spi_csn = 1'b0;
    wait_clk(4);
    shift_bits(128'h0123_4567_89AB_CDEF_0F0F_F0F0, 40);
    nrst = 1'b0;
    #2;
    check("midreset_rdata", rdata, '0);
    check("midreset_busy", NB'(busy), NB'(0));
    spi_csn  = 1'b1;
    spi_sclk = 1'b1;
    spi_mosi = 1'b0;
    last_good = '0;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(10);
    check("after_reset_rdata", rdata, '0);
    expect_ok(96'h0123_4567_89AB_CDEF_0F0F_F0F0);
    send_frame(128'h0123_4567_89AB_CDEF_0F0F_F0F0, 96, 12);

    // Back-to-back frames with a 2-cycle csn high gap
    expect_ok(96'h1);
    send_frame(128'h1, 96, 2);
    expect_ok(96'h2);
    send_frame(128'h2, 96, 12);

    // csn held low across reset release: no frame may start
    spi_csn = 1'b0;
    wait_clk(2);
    nrst = 1'b0;
    last_good = '0;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(10);
    check_idle("busy_csn_low_at_release");
    for (int i = 0; i < 5; i++) begin
      spi_sclk = 1'b0;
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
    end
    spi_csn = 1'b1;
    wait_clk(12);
    check("csn_low_release_rdata", rdata, '0);
    expect_ok(96'hFEDC_BA98_7654_3210_AAAA_5555);
    send_frame(128'hFEDC_BA98_7654_3210_AAAA_5555, 96, 12);

    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      wait_clk(1);
      budget--;
    end
    check("scoreboard_drained", NB'(exp_q.size()), NB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
